// File: rtl/display_shift_out_pkg.sv
// Shared types and constants for the serial 7-segment display driver.
package display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_e;

  // Segment byte layout {dp,g,f,e,d,c,b,a}, active high
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Minimum 1 so a counter never collapses to zero width
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/display_shift_out_if.sv
// Control/data bundle between the result path and the serial display driver.
interface display_shift_out_if #(parameter int NUM_DIGITS = 4);
  logic                      enable;
  logic                      start;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      data_out;
  logic                      sclk_out;
  logic                      latch_out;
  logic                      sending_data;
  logic                      done;

  modport master (
    output enable, start, bcd_in, dp_in,
    input  data_out, sclk_out, latch_out, sending_data, done
  );

  modport slave (
    input  enable, start, bcd_in, dp_in,
    output data_out, sclk_out, latch_out, sending_data, done
  );
endinterface

// File: rtl/display_shift_out_bcd_to_seg.sv
// One BCD nibble plus decimal point to a 7-segment byte; A-F show a dash.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  logic [7:0] raw;

  always_comb begin
    raw = SEG_DASH;
    case (bcd_i)
      4'd0: raw = SEG_0;
      4'd1: raw = SEG_1;
      4'd2: raw = SEG_2;
      4'd3: raw = SEG_3;
      4'd4: raw = SEG_4;
      4'd5: raw = SEG_5;
      4'd6: raw = SEG_6;
      4'd7: raw = SEG_7;
      4'd8: raw = SEG_8;
      4'd9: raw = SEG_9;
      default: raw = SEG_DASH;
    endcase
  end

  assign seg_o = raw | {dp_i, 7'b0};
endmodule

// File: rtl/display_shift_out.sv
// Captures a BCD frame and shifts it to a 595-style chain with paced sclk and latch.
// Optional leading-zero blanking: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_shift_out
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int MSB_FIRST  = 1
) (
  input logic               clk,
  input logic               rst,
  display_shift_out_if.slave bus
);
  localparam int FW = 8 * NUM_DIGITS;
  localparam int BW = clog2(FW);
  localparam int DW = clog2(2 * CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);

  logic [NUM_DIGITS-1:0][7:0] seg_raw, seg;
  logic [NUM_DIGITS-1:0]      blank;
  logic [FW-1:0]              frame;

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  logic lz_run;
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int d = NUM_DIGITS - 1; d > 0; d--) begin
      lz_run   = lz_run & (bus.bcd_in[4*d +: 4] == 4'd0);
      blank[d] = lz_run;
    end
  end
`else
  assign blank = '0;
`endif

  // frame[FW-1] is the first bit on the wire
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    bcd_to_seg u_seg (
      .bcd_i (bus.bcd_in[4*d +: 4]),
      .dp_i  (bus.dp_in[d]),
      .seg_o (seg_raw[d])
    );
    assign seg[d] = blank[d] ? {bus.dp_in[d], 7'b0} : seg_raw[d];
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign frame[8*d + b] = (MSB_FIRST != 0) ? seg[d][b] : seg[d][7-b];
    end
  end

  state_e        state_q;
  logic [BW-1:0] bit_q;
  logic [DW-1:0] div_q;
  logic [FW-1:0] sh_q;
  logic          sclk_q, latch_q, send_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      div_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && bus.enable) begin
          state_q <= SHIFT;
          sh_q    <= frame;
          bit_q   <= '0;
          div_q   <= '0;
          sclk_q  <= 1'b0;
          send_q  <= 1'b1;
        end
        SHIFT: if (bus.enable) begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              state_q <= LATCH;
              bit_q   <= '0;
              sh_q    <= '0;
              latch_q <= 1'b1;
            end else begin
              bit_q <= bit_q + BW'(1);
              sh_q  <= {sh_q[FW-2:0], 1'b0};
            end
          end else begin
            div_q <= div_q + DW'(1);
            if (div_q == DIV_HALF) sclk_q <= 1'b1;
          end
        end
        LATCH: if (bus.enable) begin
          if (div_q == DIV_HALF) begin
            state_q <= DONE;
            div_q   <= '0;
            latch_q <= 1'b0;
            send_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        // done is a fixed one-cycle pulse, independent of enable
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = sh_q[FW-1];
  assign bus.sclk_out     = sclk_q;
  assign bus.latch_out    = latch_q;
  assign bus.sending_data = send_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_display_shift_out.sv
// Bench for display_shift_out: cycle model per instance plus directed frame checks.
module tb_display_shift_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_shift_out_if #(.NUM_DIGITS(4)) if0 ();
  display_shift_out_if #(.NUM_DIGITS(6)) if1 ();

  display_shift_out #(.NUM_DIGITS(4), .CLK_DIV(2), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  display_shift_out #(.NUM_DIGITS(6), .CLK_DIV(1), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] segc(input logic [3:0] v);
    case (v)
      4'd0: return 8'h3F; 4'd1: return 8'h06; 4'd2: return 8'h5B; 4'd3: return 8'h4F;
      4'd4: return 8'h66; 4'd5: return 8'h6D; 4'd6: return 8'h7D; 4'd7: return 8'h07;
      4'd8: return 8'h7F; 4'd9: return 8'h6F;
      default: return 8'h40;
    endcase
  endfunction

  // Wire-order bitstream of a frame: s[0] is the first bit shifted out
  function automatic logic [47:0] build(input int n, input int msb,
                                        input logic [23:0] bcd, input logic [5:0] dp);
    logic [47:0] s;
    logic [7:0]  b;
    int          i;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    s = '0;
    i = 0;
    for (int d = n - 1; d >= 0; d--) begin
      b = segc(bcd[4*d +: 4]);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      if (bcd[4*d +: 4] != 4'd0) lead = 1'b0;
      if (lead && d > 0) b = 8'h00;
`endif
      b = b | {dp[d], 7'b0};
      for (int k = 0; k < 8; k++) begin
        s[i] = (msb != 0) ? b[7-k] : b[k];
        i++;
      end
    end
    return s;
  endfunction

  function automatic logic [7:0] sbyte(input logic [47:0] s, input int idx);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = s[8*idx + i];
    return b;
  endfunction

  // Expected {data,sclk,latch,sending,done} at frame-relative cycle j
  function automatic logic [4:0] expo(input logic busy, input int j, input int cd,
                                      input int fw, input logic [47:0] bits);
    int ts;
    ts = 2 * cd * fw;
    if (!busy) return 5'b00000;
    if (j < ts) return {bits[j / (2*cd)], ((j % (2*cd)) >= cd), 1'b0, 1'b1, 1'b0};
    if (j < ts + cd) return 5'b00110;
    return 5'b00001;
  endfunction

  logic        mbusy [2] = '{1'b0, 1'b0};
  int          mj    [2] = '{0, 0};
  logic [47:0] mbits [2];
  int          mcd   [2] = '{2, 1};
  int          mfw   [2] = '{32, 48};

  always @(posedge clk) begin
    if (rst) begin
      mbusy[0] <= 1'b0;
      mbusy[1] <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!mbusy[k]) begin
          if (k == 0 ? (if0.start && if0.enable) : (if1.start && if1.enable)) begin
            mbusy[k] <= 1'b1;
            mj[k]    <= 0;
            mbits[k] <= (k == 0) ? build(4, 1, {8'h0, if0.bcd_in}, {2'b0, if0.dp_in})
                                 : build(6, 0, if1.bcd_in, if1.dp_in);
          end
        end else if (mj[k] == 2*mcd[k]*mfw[k] + mcd[k]) begin
          mbusy[k] <= 1'b0;
        end else if (k == 0 ? if0.enable : if1.enable) begin
          mj[k] <= mj[k] + 1;
        end
      end
    end
  end

  bit   cmp_on = 1'b0;
  logic [1:0] psclk = 2'b00;
  bit   cap0[$];
  bit   cap1[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk($sformatf("dut0 outputs t=%0t", $time),
          32'({if0.data_out, if0.sclk_out, if0.latch_out, if0.sending_data, if0.done}),
          32'(expo(mbusy[0], mj[0], 2, 32, mbits[0])));
      chk($sformatf("dut1 outputs t=%0t", $time),
          32'({if1.data_out, if1.sclk_out, if1.latch_out, if1.sending_data, if1.done}),
          32'(expo(mbusy[1], mj[1], 1, 48, mbits[1])));
      if (if0.sclk_out && !psclk[0]) cap0.push_back(if0.data_out);
      if (if1.sclk_out && !psclk[1]) cap1.push_back(if1.data_out);
    end
    psclk <= {if1.sclk_out, if0.sclk_out};
  end

  function automatic logic [7:0] qbyte(input int k, input int idx, input int msb);
    logic [7:0] b;
    logic       v;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      v = (k == 0) ? cap0[8*idx + i] : cap1[8*idx + i];
      if (msb != 0) b[7-i] = v; else b[i] = v;
    end
    return b;
  endfunction

  int dq[$];
  int lat_n, lat_first;

  // Caller sits just after a rising edge; cycle c ends at the edge that samples it.
  task automatic run0(input logic [15:0] bcd, input logic [3:0] dp, input int ncyc,
                      input int pause_at, input int rst_at, input bit busy_starts);
    cap0.delete();
    dq.delete();
    lat_n = 0;
    lat_first = -1;
    if0.bcd_in = bcd;
    if0.dp_in  = dp;
    if0.enable = 1'b1;
    if0.start  = 1'b1;
    @(posedge clk); #2;
    if0.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (if0.done) dq.push_back(c);
      if (if0.latch_out) begin
        lat_n++;
        if (lat_first < 0) lat_first = c;
      end
      if0.enable = !(pause_at >= 0 && c >= pause_at && c < pause_at + 10);
      rst        = (c == rst_at);
      if0.start  = busy_starts && (c == 20 || c == 131 || c == 132);
      @(posedge clk); #2;
    end
    if0.enable = 1'b1;
    if0.start  = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic check_bytes0(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    chk({nm, " byte0"}, 32'(qbyte(0, 0, 1)), 32'(b0));
    chk({nm, " byte1"}, 32'(qbyte(0, 1, 1)), 32'(b1));
    chk({nm, " byte2"}, 32'(qbyte(0, 2, 1)), 32'(b2));
    chk({nm, " byte3"}, 32'(qbyte(0, 3, 1)), 32'(b3));
  endtask

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] T2_FIRST = 8'h00;
`else
  localparam logic [7:0] T2_FIRST = 8'h3F;
`endif

  logic [47:0] ms;

  initial begin
    if0.enable = 1'b0; if0.start = 1'b0; if0.bcd_in = '0; if0.dp_in = '0;
    if1.enable = 1'b0; if1.start = 1'b0; if1.bcd_in = '0; if1.dp_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset outputs dut0", 32'({if0.data_out, if0.sclk_out, if0.latch_out, if0.sending_data, if0.done}), 32'h0);
    chk("reset outputs dut1", 32'({if1.data_out, if1.sclk_out, if1.latch_out, if1.sending_data, if1.done}), 32'h0);
    cmp_on = 1'b1;

    // Pin the model against hand-derived streams
    ms = build(4, 1, 24'h2571, 6'b0);
    chk("model first bits", 32'({ms[0], ms[1], ms[2], ms[3], ms[4], ms[5], ms[6], ms[7]}), 32'b01011011);
    chk("model 2571 byte1", 32'(sbyte(ms, 1)), 32'h6D);
    ms = build(4, 1, 24'h0A09, 6'b000010);
    chk("model 0A09 byte0", 32'(sbyte(ms, 0)), 32'(T2_FIRST));
    chk("model 0A09 byte2", 32'(sbyte(ms, 2)), 32'hBF);

    // 1: basic frame
    run0(16'h2571, 4'b0000, 140, -1, -1, 1'b0);
    check_bytes0("basic", 8'h5B, 8'h6D, 8'h07, 8'h06);
    chk("basic bits", 32'(cap0.size()), 32);
    chk("basic latch first", 32'(lat_first), 129);
    chk("basic latch len", 32'(lat_n), 2);
    chk("basic done count", 32'(dq.size()), 1);
    if (dq.size() > 0) chk("basic done cycle", 32'(dq[0]), 131);

    // 2: invalid nibble and decimal point
    run0(16'h0A09, 4'b0010, 140, -1, -1, 1'b0);
    check_bytes0("dash_dp", T2_FIRST, 8'h40, 8'hBF, 8'h6F);

    // 3: pause mid-frame
    run0(16'h2571, 4'b0000, 150, 50, -1, 1'b0);
    check_bytes0("pause", 8'h5B, 8'h6D, 8'h07, 8'h06);
    chk("pause done count", 32'(dq.size()), 1);
    if (dq.size() > 0) chk("pause done cycle", 32'(dq[0]), 141);

    // 4: reset mid-frame, then a clean frame
    run0(16'h2571, 4'b0000, 160, -1, 40, 1'b0);
    chk("abort latch", 32'(lat_n), 0);
    chk("abort done", 32'(dq.size()), 0);
    run0(16'h9384, 4'b1000, 140, -1, -1, 1'b0);
    check_bytes0("after_rst", 8'hEF, 8'h4F, 8'h7F, 8'h66);
    if (dq.size() > 0) chk("after_rst done cycle", 32'(dq[0]), 131);
    else chk("after_rst done seen", 32'(dq.size()), 1);

    // 5: starts while busy are dropped; the one after DONE launches
    run0(16'h2571, 4'b0000, 280, -1, -1, 1'b1);
    chk("busy done count", 32'(dq.size()), 2);
    if (dq.size() == 2) begin
      chk("busy done0", 32'(dq[0]), 131);
      chk("busy done1", 32'(dq[1]), 263);
    end
    chk("busy bits", 32'(cap0.size()), 64);

    // 6: N=6, CLK_DIV=1, seg a first
    cap1.delete();
    dq.delete();
    if1.bcd_in = 24'h908172;
    if1.dp_in  = 6'b100001;
    if1.enable = 1'b1;
    if1.start  = 1'b1;
    @(posedge clk); #2;
    if1.start = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      if (if1.done) dq.push_back(c);
      @(posedge clk); #2;
    end
    chk("n6 bits", 32'(cap1.size()), 48);
    chk("n6 byte0", 32'(qbyte(1, 0, 0)), 32'hEF);
    chk("n6 byte1", 32'(qbyte(1, 1, 0)), 32'h3F);
    chk("n6 byte5", 32'(qbyte(1, 5, 0)), 32'hDB);
    chk("n6 done count", 32'(dq.size()), 1);
    if (dq.size() > 0) chk("n6 done cycle", 32'(dq[0]), 98);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
